debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter NUM_BTN, 4, number of independent button channels (1..32).
REQ-002 Parameter CLK_DIV, 50000, clk cycles per sample tick (>=2).
REQ-003 Parameter DEBOUNCE_TICKS, 16, consecutive ticks of a differing input needed to accept a change (1..255).
REQ-004 Parameter LONG_TICKS, 1000, ticks of held press before a long-press pulse; 0 disables long-press detection.
REQ-005 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port in_button  input  NUM_BTN  raw, asynchronous, bouncing button levels (1 = pressed).
REQ-008 Port out_button  output  NUM_BTN  debounced stable level per channel.
REQ-009 Port btn_press  output  NUM_BTN  one-clk pulse per channel on an accepted 0->1 change.
REQ-010 Port btn_release  output  NUM_BTN  one-clk pulse per channel on an accepted 1->0 change.
REQ-011 Port btn_long  output  NUM_BTN  one-clk pulse per channel when a press has been held LONG_TICKS ticks.

Function
REQ-012 Each in_button bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 A shared prescaler SHALL count 0..CLK_DIV-1 and assert an internal tick for exactly one clk cycle when at CLK_DIV-1, then wrap to 0; tick is a clock enable, never a clock.
REQ-014 All channel state SHALL update only in clk cycles where tick is high, except that pulse outputs clear on the following cycle.
REQ-015 Per channel on tick: synchronized input != out_button -> change counter increments; synchronized input == out_button -> change counter clears to 0 (bounce restarts the window).
REQ-016 When the change counter would reach DEBOUNCE_TICKS, out_button SHALL take the synchronized value and the counter SHALL clear, in the same update.
REQ-017 btn_press/btn_release SHALL be high for exactly one clk cycle, coincident with the first cycle the new out_button value is visible.
REQ-018 Hold counter per channel SHALL count ticks while out_button = 1, saturate at LONG_TICKS, and clear when out_button = 0.
REQ-019 btn_long SHALL pulse once per press, in the cycle after the tick on which the hold counter reaches LONG_TICKS; no repeat until release and new press.
REQ-020 Release before LONG_TICKS SHALL produce btn_release only, no btn_long.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-022 Latency from a clean input edge to out_button change SHALL be 2 clk (sync) plus DEBOUNCE_TICKS ticks, tolerance one tick period.
REQ-023 Counter widths SHALL be the minimum holding DEBOUNCE_TICKS, LONG_TICKS and CLK_DIV-1 without wrap.

Reset
REQ-024 rst_n low SHALL asynchronously clear synchronizers, prescaler, all counters, out_button, btn_press, btn_release and btn_long to 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard progress; after release, a held button SHALL be re-accepted as a new press after the full debounce window.
REQ-026 Reset deassertion SHALL be used synchronously by the logic; the first tick occurs CLK_DIV cycles after deassertion.

Structure
REQ-027 Package debounce_pkg SHALL hold the counter-width helper function and the default parameter constants.
REQ-028 Per-channel logic (change counter, level, hold counter, pulse generation) SHALL be sub-module debounce_channel, instantiated NUM_BTN times by generate; synchronizer and prescaler stay in debounce_bank.

Verification (NUM_BTN=4, CLK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=5)
REQ-029 Reset, all inputs 0 -> all outputs 0; tick high every 4th clk starting 4 clk after rst_n rises.
REQ-030 in_button[0] 0->1 held clean -> out_button[0]=1 and single btn_press[0] pulse within 2+3*4 (+/-4) clk; other channels stay 0.
REQ-031 in_button[1] toggled 1 for 2 ticks, 0 for 1 tick, then 1 steady -> no press until 3 consecutive ticks after final rise.
REQ-032 Hold in_button[2] for 3+5 ticks -> btn_press[2], then exactly one btn_long[2]; release -> btn_release[2], no further btn_long.
REQ-033 Press channels 0 and 3 in same cycle -> btn_press = 4'b1001 in one cycle.
REQ-034 rst_n pulsed low during a held, accepted press -> outputs clear immediately; after release a fresh btn_press after 3 ticks.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, counter-width helper and per-channel event payload for the debounce bank.
package debounce_pkg;

  localparam int unsigned DEFAULT_NUM_BTN        = 4;
  localparam int unsigned DEFAULT_CLK_DIV        = 50000;
  localparam int unsigned DEFAULT_DEBOUNCE_TICKS = 16;
  localparam int unsigned DEFAULT_LONG_TICKS     = 1000;

  // Minimum number of bits that can hold max_val without wrapping (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // One-clk event pulses produced by a single channel.
  typedef struct packed {
    logic held_long;
    logic released;
    logic pressed;
  } btn_evt_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: change-window debounce, stable level, hold timer and event pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int unsigned LONG_TICKS     = DEFAULT_LONG_TICKS
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick_i,
  input  logic     din_i,
  output logic     level_o,
  output btn_evt_t evt_o
);

  localparam int unsigned CW      = cnt_width(DEBOUNCE_TICKS);
  localparam int unsigned HW      = cnt_width(LONG_TICKS);
  localparam bit          LONG_EN = (LONG_TICKS != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  btn_evt_t      evt_q, evt_d;

  // Next-state: all state moves on tick only; pulses default low so they last one clk.
  always_comb begin
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    evt_d   = '0;
    if (tick_i) begin
      if (din_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        cnt_d          = '0;
        level_d        = din_i;
        evt_d.pressed  = din_i;
        evt_d.released = ~din_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      // Hold timer runs on ticks after the press was accepted; a release clears it.
      if (!level_d) begin
        hold_d = '0;
      end else if (LONG_EN && level_q && (hold_q != HW'(LONG_TICKS))) begin
        hold_d          = hold_q + HW'(1);
        evt_d.held_long = (hold_d == HW'(LONG_TICKS));
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end

  assign level_o = level_q;
  assign evt_o   = evt_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of button debouncers sharing one input synchronizer stage and one sample prescaler.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_BTN        = DEFAULT_NUM_BTN,
  parameter int unsigned CLK_DIV        = DEFAULT_CLK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int unsigned LONG_TICKS     = DEFAULT_LONG_TICKS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] in_button,
  output logic [NUM_BTN-1:0] out_button,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int unsigned DW = cnt_width(CLK_DIV - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [DW-1:0]      div_q, div_d;
  logic               tick_c;

  // Two-flop synchronizer for the raw asynchronous button levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_button;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler next-state: tick is a one-clk enable at the top of the count.
  always_comb begin
    tick_c = (div_q == DW'(CLK_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_evt_t evt;

    debounce_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick_c),
      .din_i   (sync2_q[i]),
      .level_o (out_button[i]),
      .evt_o   (evt)
    );

    assign btn_press[i]   = evt.pressed;
    assign btn_release[i] = evt.released;
    assign btn_long[i]    = evt.held_long;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed/randomized bench for debounce_bank with a tick-level behavioural reference model.
module tb_debounce_bank;

  localparam int unsigned NB = 4;
  localparam int unsigned CD = 4;
  localparam int unsigned DT = 3;
  localparam int unsigned LT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] in_button = '0;
  logic [NB-1:0] out_button, btn_press, btn_release, btn_long;

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_BTN        (NB),
    .CLK_DIV        (CD),
    .DEBOUNCE_TICKS (DT),
    .LONG_TICKS     (LT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_button   (in_button),
    .out_button  (out_button),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  int checks = 0;
  int errors = 0;
  int n_press[NB];
  int n_rel[NB];
  int n_long[NB];

  // Reference model: samples taken every CD-th clk after reset; a level flips once the
  // last DT samples all disagree with it; long fires LT ticks after an accepted press.
  logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
  logic [NB-1:0] m_hist[$];
  int            m_edges;
  int            m_held[NB];
  logic          flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      m_edges = 0;
      m_hist.delete();
      for (int c = 0; c < NB; c++) m_held[c] = -1;
    end else begin
      m_press = '0; m_rel = '0; m_long = '0;
      m_edges++;
      if (m_edges % CD == 0) begin
        m_hist.push_back(m_s2);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        for (int c = 0; c < NB; c++) begin
          flip = (m_hist.size() >= DT);
          for (int k = 0; k < DT; k++) begin
            if (flip && (m_hist[m_hist.size() - 1 - k][c] == m_level[c])) flip = 1'b0;
          end
          if (flip) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) begin
              m_press[c] = 1'b1; m_held[c] = 0;
            end else begin
              m_rel[c] = 1'b1; m_held[c] = -1;
            end
          end else if (m_held[c] >= 0) begin
            m_held[c]++;
            if (m_held[c] == LT) m_long[c] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = in_button;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_button",  32'(out_button),  32'(m_level));
    chk("btn_press",   32'(btn_press),   32'(m_press));
    chk("btn_release", 32'(btn_release), 32'(m_rel));
    chk("btn_long",    32'(btn_long),    32'(m_long));
    for (int c = 0; c < NB; c++) begin
      n_press[c] += int'(btn_press[c]);
      n_rel[c]   += int'(btn_release[c]);
      n_long[c]  += int'(btn_long[c]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic clr_counts();
    for (int c = 0; c < NB; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
    end
  endtask

  task automatic wait_level(input int ch, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      cyc(1);
      if (out_button[ch]) begin
        seen = 1'b1;
        lat  = k;
      end
    end
  endtask

  int lat;
  bit seen;
  bit both;

  initial begin
    clr_counts();
    // Reset with all inputs low.
    cyc(3);
    chk("reset_out", 32'(out_button), 32'h0);
    chk("reset_evt", 32'({btn_press, btn_release, btn_long}), 32'h0);
    rst_n = 1'b1;
    cyc(12);

    // Clean press on channel 0: single press pulse, others untouched.
    clr_counts();
    in_button[0] = 1'b1;
    wait_level(0, lat, seen);
    chk("press0_seen", 32'(seen), 32'd1);
    chk("press0_latency_ok", 32'(lat >= 10 && lat <= 18), 32'd1);
    cyc(6);
    chk("press0_count", 32'(n_press[0]), 32'd1);
    chk("press_others", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);
    chk("others_level", 32'(out_button[3:1]), 32'h0);

    // Channel 1 bounce: 2 ticks high, 1 tick low, then steady high.
    clr_counts();
    in_button[1] = 1'b1; cyc(2 * CD);
    in_button[1] = 1'b0; cyc(CD);
    in_button[1] = 1'b1;
    chk("ch1_no_early_press", 32'(n_press[1]), 32'd0);
    cyc(10);
    chk("ch1_not_yet", 32'(out_button[1]), 32'd0);
    cyc(10);
    chk("ch1_accepted", 32'(out_button[1]), 32'd1);
    chk("ch1_press_once", 32'(n_press[1]), 32'd1);

    // Randomized bouncing on all channels, then settling to a random level.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 20; k++) begin
        in_button = NB'($urandom);
        cyc(1);
      end
      in_button = NB'($urandom);
      cyc(int'($urandom_range(20, 40)));
    end

    // Long hold on channel 2 and short hold on channel 3.
    in_button = '0;
    cyc(30);
    clr_counts();
    in_button[2] = 1'b1;
    in_button[3] = 1'b1;
    cyc(16);
    in_button[3] = 1'b0;
    cyc(34);
    chk("ch2_press", 32'(n_press[2]), 32'd1);
    chk("ch2_long_once", 32'(n_long[2]), 32'd1);
    chk("ch3_short_no_long", 32'(n_long[3]), 32'd0);
    chk("ch3_release", 32'(n_rel[3]), 32'd1);
    in_button[2] = 1'b0;
    cyc(30);
    chk("ch2_release", 32'(n_rel[2]), 32'd1);
    chk("ch2_no_more_long", 32'(n_long[2]), 32'd1);

    // Channels 0 and 3 pressed in the same cycle.
    in_button = '0;
    cyc(30);
    in_button = 4'b1001;
    both = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      if (btn_press === 4'b1001) both = 1'b1;
    end
    chk("press_0_3_same_cycle", 32'(both), 32'd1);

    // Reset during an accepted, held press; re-acceptance after release.
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("midreset_out", 32'(out_button), 32'h0);
    chk("midreset_evt", 32'({btn_press, btn_release, btn_long}), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    clr_counts();
    wait_level(0, lat, seen);
    chk("repress0_seen", 32'(seen), 32'd1);
    chk("repress0_latency_ok", 32'(lat >= 10 && lat <= 18), 32'd1);
    cyc(4);
    chk("repress0_count", 32'(n_press[0]), 32'd1);
    chk("repress3_count", 32'(n_press[3]), 32'd1);
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
